// File: rtl/cdb_arbiter.sv
// cdb_arbiter: drive side of the common data bus.
// Each functional unit hands its completed result to a one-entry slot through a
// valid/ready handshake. Each cycle at most one occupied slot is granted onto
// the bus, chosen round-robin. The branch unit slot also carries the
// mispredict flag and redirect PC. A flush or reset empties every slot.
//
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   flush                discard all held and incoming results this cycle
//   fu_valid/fu_value/fu_rob_tag   per-FU result handshake and payload
//   btu_mispredict/btu_pc          branch unit extras, sampled with its valid
//   fu_ready             per-slot accept indication (combinational)
//   select_flag/select_signal/ROB_tag   broadcast valid, granted slot, its tag
//   in_values            all slot value registers
//   mispredict/pc        branch unit slot registers
module cdb_arbiter #(
  parameter int unsigned FU_NUM      = 4,
  parameter int unsigned BTU_IDX     = 3,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ROB_TAG_LEN = 6
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                flush,
  input  logic [FU_NUM-1:0]                   fu_valid,
  input  logic [FU_NUM-1:0][XLEN-1:0]         fu_value,
  input  logic [FU_NUM-1:0][ROB_TAG_LEN-1:0]  fu_rob_tag,
  input  logic                                btu_mispredict,
  input  logic [XLEN-1:0]                     btu_pc,
  output logic [FU_NUM-1:0]                   fu_ready,
  output logic                                select_flag,
  output logic [$clog2(FU_NUM)-1:0]           select_signal,
  output logic [ROB_TAG_LEN-1:0]              ROB_tag,
  output logic [FU_NUM-1:0][XLEN-1:0]         in_values,
  output logic                                mispredict,
  output logic [XLEN-1:0]                     pc
);

  localparam int unsigned SW = $clog2(FU_NUM);

  logic [FU_NUM-1:0]                  occ;
  logic [FU_NUM-1:0][XLEN-1:0]        val;
  logic [FU_NUM-1:0][ROB_TAG_LEN-1:0] tag;
  logic                               mp;
  logic [XLEN-1:0]                    bpc;
  logic [SW-1:0]                      rr_ptr;

  logic [SW-1:0]                      grant;
  logic                               found;

  // Round-robin search: first occupied slot starting at rr_ptr, wrapping.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < FU_NUM; k++) begin
      int unsigned j;
      j = (32'(rr_ptr) + k) % FU_NUM;
      if (!found && occ[j]) begin
        found = 1'b1;
        grant = SW'(j);
      end
    end
  end

  // Bus drive; nothing is broadcast during reset or flush.
  always_comb begin
    select_flag   = found && !flush && !reset;
    select_signal = select_flag ? grant : '0;
    ROB_tag       = select_flag ? tag[grant] : '0;
    in_values     = val;
    mispredict    = mp;
    pc            = bpc;
  end

  // A slot accepts when empty, or when it is being drained this same cycle.
  always_comb begin
    fu_ready = '0;
    for (int unsigned i = 0; i < FU_NUM; i++) begin
      fu_ready[i] = !reset && !flush &&
                    (!occ[i] || (select_flag && (grant == SW'(i))));
    end
  end

  // Slot capture/release and pointer update; a refill overrides the release.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      occ    <= '0;
      val    <= '0;
      tag    <= '0;
      mp     <= 1'b0;
      bpc    <= '0;
      rr_ptr <= '0;
    end else begin
      for (int unsigned i = 0; i < FU_NUM; i++) begin
        if (fu_valid[i] && fu_ready[i]) begin
          occ[i] <= 1'b1;
          val[i] <= fu_value[i];
          tag[i] <= fu_rob_tag[i];
          if (i == BTU_IDX) begin
            mp  <= btu_mispredict;
            bpc <= btu_pc;
          end
        end else if (select_flag && (grant == SW'(i))) begin
          occ[i] <= 1'b0;
          val[i] <= '0;
          tag[i] <= '0;
          if (i == BTU_IDX) begin
            mp  <= 1'b0;
            bpc <= '0;
          end
        end
      end
      if (select_flag) begin
        rr_ptr <= SW'((32'(grant) + 32'd1) % FU_NUM);
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed stimulus pushes expected broadcasts into
// a queue; a negedge monitor pops and compares whenever select_flag is high.
module tb_cdb_arbiter;

  localparam int unsigned FU_NUM = 4;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned TL     = 6;

  logic                          clock = 1'b0;
  logic                          reset;
  logic                          flush;
  logic [FU_NUM-1:0]             fu_valid;
  logic [FU_NUM-1:0][XLEN-1:0]   fu_value;
  logic [FU_NUM-1:0][TL-1:0]     fu_rob_tag;
  logic                          btu_mispredict;
  logic [XLEN-1:0]               btu_pc;
  logic [FU_NUM-1:0]             fu_ready;
  logic                          select_flag;
  logic [1:0]                    select_signal;
  logic [TL-1:0]                 ROB_tag;
  logic [FU_NUM-1:0][XLEN-1:0]   in_values;
  logic                          mispredict;
  logic [XLEN-1:0]               pc;

  typedef struct {
    logic [1:0]      slot;
    logic [TL-1:0]   tag;
    logic [XLEN-1:0] value;
    logic            mp;
    logic [XLEN-1:0] pc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  cdb_arbiter #(.FU_NUM(FU_NUM), .BTU_IDX(3), .XLEN(XLEN), .ROB_TAG_LEN(TL)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_value(fu_value), .fu_rob_tag(fu_rob_tag),
    .btu_mispredict(btu_mispredict), .btu_pc(btu_pc),
    .fu_ready(fu_ready), .select_flag(select_flag), .select_signal(select_signal),
    .ROB_tag(ROB_tag), .in_values(in_values), .mispredict(mispredict), .pc(pc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int s, input int t, input logic [XLEN-1:0] v,
                      input logic m, input logic [XLEN-1:0] p);
    exp_t e;
    e.slot = 2'(s); e.tag = TL'(t); e.value = v; e.mp = m; e.pc = p;
    q.push_back(e);
  endtask

  // Drive point: just after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (!reset && select_flag) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bcast: slot %0d tag %0h with no expected entry",
                 select_signal, ROB_tag);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("bcast_slot", 128'(select_signal), 128'(e.slot));
        chk("bcast_tag", 128'(ROB_tag), 128'(e.tag));
        chk("bcast_value", 128'(in_values[select_signal]), 128'(e.value));
        chk("bcast_mp", 128'(mispredict), 128'(e.mp));
        chk("bcast_pc", 128'(pc), 128'(e.pc));
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; fu_valid = '0; fu_value = '0; fu_rob_tag = '0;
    btu_mispredict = 1'b0; btu_pc = '0;

    // Reset / idle
    @(negedge clock);
    @(negedge clock);
    chk("reset_ready", 128'(fu_ready), 128'(4'b0000));
    chk("reset_sel", 128'(select_flag), 128'(0));
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("idle_ready", 128'(fu_ready), 128'(4'b1111));
    chk("idle_sel", 128'(select_flag), 128'(0));
    chk("idle_selsig", 128'(select_signal), 128'(0));
    chk("idle_tag", 128'(ROB_tag), 128'(0));
    chk("idle_values", 128'(in_values), 128'(0));
    chk("idle_mp", 128'(mispredict), 128'(0));
    chk("idle_pc", 128'(pc), 128'(0));

    // Contention: all four at once, expect grants 0,1,2,3
    step();
    fu_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      fu_rob_tag[i] = TL'(i + 1);
      fu_value[i]   = 32'h100 + 32'(i);
      push(i, i + 1, 32'h100 + 32'(i), 1'b0, 32'h0);
    end
    step();
    fu_valid = '0;
    @(negedge clock); chk("rr_ready_c1", 128'(fu_ready), 128'(4'b0001));
    step(); @(negedge clock); chk("rr_ready_c2", 128'(fu_ready), 128'(4'b0011));
    step(); @(negedge clock); chk("rr_ready_c3", 128'(fu_ready), 128'(4'b0111));
    step(); @(negedge clock); chk("rr_ready_c4", 128'(fu_ready), 128'(4'b1111));

    // Single result on slot 0 (pointer back at 0)
    step();
    fu_valid = 4'b0001; fu_value[0] = 32'hDEADBEEF; fu_rob_tag[0] = TL'(5);
    push(0, 5, 32'hDEADBEEF, 1'b0, 32'h0);
    step();
    fu_valid = '0;
    @(negedge clock);
    chk("single_sel", 128'(select_flag), 128'(1));
    step();
    @(negedge clock);
    chk("single_after_sel", 128'(select_flag), 128'(0));
    chk("single_after_vals", 128'(in_values), 128'(0));

    // Back-to-back refill on FU1
    for (int k = 0; k < 4; k++) begin
      step();
      fu_valid = 4'b0010; fu_rob_tag[1] = TL'(10 + k); fu_value[1] = 32'h2000 + 32'(k);
      push(1, 10 + k, 32'h2000 + 32'(k), 1'b0, 32'h0);
      @(negedge clock);
      chk("b2b_ready1", 128'(fu_ready[1]), 128'(1));
    end
    step();
    fu_valid = '0;

    // BTU slot fields
    step();
    fu_valid = 4'b1000; fu_rob_tag[3] = TL'(7); fu_value[3] = 32'h33;
    btu_mispredict = 1'b1; btu_pc = 32'h80;
    push(3, 7, 32'h33, 1'b1, 32'h80);
    step();
    fu_valid = '0; btu_mispredict = 1'b0; btu_pc = '0;
    step();
    @(negedge clock);
    chk("btu_clear_mp", 128'(mispredict), 128'(0));
    chk("btu_clear_pc", 128'(pc), 128'(0));

    // Slot 1 alone moves the pointer to 2 before the flush
    step();
    fu_valid = 4'b0010; fu_rob_tag[1] = TL'(20); fu_value[1] = 32'h55;
    push(1, 20, 32'h55, 1'b0, 32'h0);
    step();
    fu_valid = '0;
    step();

    // Flush with slots 0 and 2 occupied and FU1 presenting
    fu_valid = 4'b0101; fu_rob_tag[0] = TL'(8); fu_rob_tag[2] = TL'(9);
    fu_value[0] = 32'hA0; fu_value[2] = 32'hA2;
    step();
    fu_valid = 4'b0010; fu_rob_tag[1] = TL'(12); fu_value[1] = 32'hA1; flush = 1'b1;
    @(negedge clock);
    chk("flush_sel", 128'(select_flag), 128'(0));
    chk("flush_ready", 128'(fu_ready), 128'(4'b0000));
    step();
    fu_valid = '0; flush = 1'b0;
    @(negedge clock);
    chk("postflush_sel", 128'(select_flag), 128'(0));
    chk("postflush_vals", 128'(in_values), 128'(0));
    chk("postflush_ready", 128'(fu_ready), 128'(4'b1111));

    // Pointer must be 0 after flush: slots 1 and 2 grant in order 1,2
    step();
    fu_valid = 4'b0110; fu_rob_tag[1] = TL'(30); fu_value[1] = 32'hB1;
    fu_rob_tag[2] = TL'(31); fu_value[2] = 32'hB2;
    push(1, 30, 32'hB1, 1'b0, 32'h0);
    push(2, 31, 32'hB2, 1'b0, 32'h0);
    step();
    fu_valid = '0;

    // Drain with a bounded wait
    for (int n = 0; n < 20 && q.size() != 0; n++) step();
    repeat (3) step();
    chk("queue_drained", 128'(q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
